// File: rtl/tone_detector_if.sv
// tone_detector_if: bundles the audio input and the decoded-note outputs of
// the tone detector.
//   audio_in    : external square wave (asynchronous to the clock)
//   note        : 0 = none, 1..7 = A4..G5
//   note_valid  : high while note != 0
//   note_change : one-cycle pulse whenever note changes value
//   half_period : last measured half-period in clock cycles
// master = the side that drives audio_in and observes the result,
// slave  = the detector itself.
`timescale 1ns/1ps
interface tone_detector_if;
  logic        audio_in;
  logic [2:0]  note;
  logic        note_valid;
  logic        note_change;
  logic [16:0] half_period;

  modport master (
    output audio_in,
    input  note, note_valid, note_change, half_period
  );

  modport slave (
    input  audio_in,
    output note, note_valid, note_change, half_period
  );
endinterface

// File: rtl/tone_detector.sv
// tone_detector: measures the half-period of a 1-bit square wave and decodes
// it to one of the piano notes A4..G5.
// Ports:
//   clk_25mhz : system clock
//   reset     : asynchronous, active-high reset
//   bus       : tone_detector_if.slave (audio_in in; note, note_valid,
//               note_change, half_period out)
// Flow: 2-FF synchronizer -> edge detect -> edge-to-edge counter (IDLE/ARMED)
// -> classify against the note table -> stability filter -> outputs.
`timescale 1ns/1ps
module tone_detector #(
  parameter int CLK_HZ     = 25000000,
  parameter int TOL_SHIFT  = 5,
  parameter int MIN_STABLE = 2,
  parameter int TIMEOUT    = 100000
) (
  input  logic           clk_25mhz,
  input  logic           reset,
  tone_detector_if.slave bus
);

  localparam int STAB_W = $clog2(MIN_STABLE + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(MIN_STABLE);
  localparam logic [16:0]       CNT_TO   = 17'(TIMEOUT);

  typedef enum logic {IDLE, ARMED} state_t;

  // Expected half-period of note k (1 = A4 .. 7 = G5); integer division at
  // each step so the table matches the transmitter exactly.
  function automatic logic [16:0] hp_tab(input int k);
    int f;
    case (k)
      1:       f = 440;
      2:       f = 494;
      3:       f = 523;
      4:       f = 587;
      5:       f = 659;
      6:       f = 698;
      default: f = 783;
    endcase
    return 17'((CLK_HZ / f) / 2);
  endfunction

  function automatic logic [16:0] absdiff(input logic [16:0] a, input logic [16:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Lowest matching note wins: scan downwards so later (lower) hits overwrite.
  function automatic logic [2:0] classify(input logic [16:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 7; k >= 1; k--) begin
      if (absdiff(m, hp_tab(k)) <= (hp_tab(k) >> TOL_SHIFT)) r = 3'(k);
    end
    return r;
  endfunction

  logic [1:0]        sync_q;
  logic              prev_q;
  logic              edge_p0;
  state_t            state_q, state_d;
  logic [16:0]       cnt_q, cnt_d;
  logic              meas_vld, timeout;
  logic              vld_p1_q;
  logic [16:0]       hp_p1_q;
  logic [2:0]        cand_p1_q;
  logic [2:0]        prev_cand_q, prev_cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [2:0]        note_q, note_d;
  logic              note_valid_q;
  logic              chg_q, chg_d;

  // ---- stage p0: synchronizer, edge detect, edge-to-edge counter ----
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.audio_in};
      prev_q <= sync_q[1];
    end
  end

  assign edge_p0 = sync_q[1] ^ prev_q;

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // An edge arriving in the timeout cycle still counts as a measurement.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (edge_p0) state_d = ARMED;
      ARMED:   if (!edge_p0 && cnt_q == CNT_TO) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    meas_vld = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: cnt_d = edge_p0 ? 17'd1 : 17'd0;
      ARMED: begin
        if (edge_p0) begin
          meas_vld = 1'b1;
          cnt_d    = 17'd1;
        end else if (cnt_q == CNT_TO) begin
          timeout = 1'b1;
          cnt_d   = 17'd0;
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      default: cnt_d = 17'd0;
    endcase
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) cnt_q <= 17'd0;
    else       cnt_q <= cnt_d;
  end

  // ---- stage p1: register measurement and table match ----
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      hp_p1_q   <= 17'd0;
      cand_p1_q <= 3'd0;
    end else begin
      vld_p1_q <= meas_vld;
      if (meas_vld) begin
        hp_p1_q   <= cnt_q;
        cand_p1_q <= classify(cnt_q);
      end
    end
  end

  // ---- stage p2: stability filter and note output ----
  always_comb begin
    prev_cand_d = prev_cand_q;
    stab_d      = stab_q;
    note_d      = note_q;
    chg_d       = 1'b0;
    if (timeout) begin
      stab_d = '0;
      note_d = 3'd0;
      chg_d  = (note_q != 3'd0);
    end else if (vld_p1_q) begin
      prev_cand_d = cand_p1_q;
      if (cand_p1_q == prev_cand_q)
        stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
      else
        stab_d = STAB_W'(1);
      if (stab_d == STAB_MAX && cand_p1_q != note_q) begin
        note_d = cand_p1_q;
        chg_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      prev_cand_q  <= 3'd0;
      stab_q       <= '0;
      note_q       <= 3'd0;
      note_valid_q <= 1'b0;
      chg_q        <= 1'b0;
    end else begin
      prev_cand_q  <= prev_cand_d;
      stab_q       <= stab_d;
      note_q       <= note_d;
      note_valid_q <= (note_d != 3'd0);
      chg_q        <= chg_d;
    end
  end

  assign bus.note        = note_q;
  assign bus.note_valid  = note_valid_q;
  assign bus.note_change = chg_q;
  assign bus.half_period = hp_p1_q;

endmodule

// File: doc/tone_detector.md
Name: tone_detector

Overview:
- Receive side of the button-piano tone generator: measures the half-period of an incoming 1-bit square wave and decodes it to one of the seven piano notes A4..G5.
- Sits between a board input pin (second board or loopback wire) and LEDs/display logic.
- Reports a stable note code, a valid flag, a change strobe and the raw measured half-period.

Parameters:
- CLK_HZ, 25000000, system clock frequency; note table entries are HP_k = CLK_HZ/f_k/2 using integer division at each step.
- TOL_SHIFT, 5, match tolerance per note is HP_k >> TOL_SHIFT (about 3%).
- MIN_STABLE, 2, number of consecutive identical classifications required before the output changes.
- TIMEOUT, 100000, cycles without an input edge before the input is declared silent.

Ports:
- clk_25mhz  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- audio_in  input  1  external square wave; asynchronous to the clock
- note  output  3  0 = none, 1 = A4, 2 = B4, 3 = C5, 4 = D5, 5 = E5, 6 = F5, 7 = G5
- note_valid  output  1  high while note != 0
- note_change  output  1  one-cycle pulse when note changes value
- half_period  output  17  last measured half-period in clk cycles

Behaviour:
- Reset (async, active-high) state:
  - outputs: note = 0, note_valid = 0, note_change = 0, half_period = 0.
  - internal: synchronizer = 0, counter = 0, stability count = 0, state = IDLE.
- Input path: 2-FF synchronizer, then a previous-value register. The edge pulse E is asserted in the cycle where the synchronized value differs from the previous value. Both polarities count.
- Default table at 25 MHz: A4 28409, B4 25303, C5 23900, D5 21294, E5 18968, F5 17908, G5 15964.
- States:
  - IDLE: counter held at 0. On E, go to ARMED and set counter to 1. No measurement is taken.
  - ARMED: counter increments by 1 per cycle.
    - On E: measured = counter (cycles between the two edge pulses); counter restarts at 1.
    - If counter reaches TIMEOUT without E: go to IDLE, force note = 0, clear stability count; note_change pulses if note was nonzero.
- Pipeline:
  - Cycle E+1: half_period is registered with the measured value. Candidate is registered as the lowest k with |measured - HP_k| <= HP_k >> TOL_SHIFT, else 0. Use an unsigned absolute difference; no wrap.
  - Cycle E+2: stability update.
    - If candidate equals the previous candidate, stability count increments, saturating at MIN_STABLE. Otherwise the count is set to 1.
    - When the count reaches MIN_STABLE and candidate != note: note = candidate, note_valid = (candidate != 0), note_change = 1 for exactly that cycle.
- Out-of-table periods therefore clear note only after MIN_STABLE consecutive no-match measurements. A single glitch period does not change the output.
- E in the same cycle the counter reaches TIMEOUT: the edge wins. The measurement is taken (it will not match the table) and the state stays ARMED.
- The counter is 17 bits wide and never wraps; it is bounded by TIMEOUT.
- Reset mid-measurement: immediate return to the reset state. The first edge after reset only arms the detector.

Test Plan:
- Reset: assert reset asynchronously mid-cycle, then hold it. Required: all outputs 0 immediately and while held. Then drive audio_in constant for 200000 cycles → outputs stay 0 and note_change never pulses.
- A4 lock:
  - Stimulus: square wave with half-period 28409 cycles.
  - First edge only arms; half_period = 28409 after the 2nd edge.
  - note = 1, note_valid = 1 and a single note_change pulse occur 2 cycles after the 3rd edge pulse (2nd matching measurement).
- Note step: switch the locked A4 to half-period 18968. Required: note = 5 after the 2nd E5 measurement, with exactly one note_change pulse. Intermediate mixed periods must not produce a spurious note.
- Tolerance boundary: half-period 28409+887 → note = 1; half-period 28409+888 (twice) → note = 0, note_valid = 0. Repeat at G5: 15964-498 matches, 15964-499 does not.
- Glitch rejection: locked on D5 (21294), insert one half-period of 20000, then continue at 21294. Required: note stays 4 with no note_change; half_period shows 20000 for that one measurement.
- Silence and reset mid-tone:
  - Locked on C5, stop toggling. Required: note = 0 with a note_change pulse exactly TIMEOUT cycles after the last edge counter restart; resumed toggling needs 3 edges to relock.
  - Pulse reset while locked. Required: immediate clear, and relock after 3 further edges.
